etapa_mem: RTL and testbench
============================

# etapa_mem

Memory stage of the segmented processor, directly downstream of the EX/MEM control register `control2`. Consumes its `Controls2`, `LeerMem`, `EscrMem` and `SaltoCond` outputs, together with the EX/MEM datapath values. Performs the data-memory access and resolves the conditional branch. Registers everything the write-back stage needs into the MEM/WB pipeline register.

## Interface
- `ANCHO`, 32, data and address width in bits.
- `PROF_MEM`, 32, data memory depth in words; must be a power of two.
- `clk`  input  1  rising-edge clock shared with `control2`.
- `reset`  input  1  asynchronous, active-high reset.
- `Controls2`  input  10  control bundle from `control2`. Bit 6 is MemaReg and bit 5 is EscrReg. All other bits are ignored here.
- `LeerMem`  input  1  load request (from `control2`).
- `EscrMem`  input  1  store request (from `control2`).
- `SaltoCond`  input  1  conditional branch instruction (from `control2`).
- `Zero`  input  1  ALU zero flag, EX/MEM copy.
- `ResultadoALU`  input  ANCHO  ALU result, which is the byte address for loads and stores.
- `DatoEscr`  input  ANCHO  store data (rt value).
- `RegDestino`  input  5  destination register number.
- `DirSalto`  input  ANCHO  branch target address.
- `FuentePC`  output  1  combinational; 1 selects `DirSaltoPC` as the next PC.
- `DirSaltoPC`  output  ANCHO  combinational pass-through of `DirSalto`.
- `EscrRegWB`  output  1  registered MEM/WB register-write enable.
- `MemaRegWB`  output  1  registered MEM/WB write-back source select (1 = memory data).
- `DatoLeidoWB`  output  ANCHO  registered load data.
- `ResultadoWB`  output  ANCHO  registered copy of `ResultadoALU`.
- `RegDestinoWB`  output  5  registered copy of `RegDestino`.
- `ErrorAlin`  output  1  registered one-cycle pulse flagging a misaligned access.

## Operation
- **Word index:** `idx = ResultadoALU[log2(PROF_MEM)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*PROF_MEM` bytes.
- **Misaligned access:** `mis = (LeerMem | EscrMem) & (ResultadoALU[1:0] != 0)`.
- **Branch:**
  - `FuentePC = SaltoCond & Zero & ~reset`.
  - No state is involved; the jump bit (Controls2[9]) is not handled here.
- **Store:** on a rising edge with `EscrMem=1` and `mis=0`, `mem[idx] <= DatoEscr`. Misaligned stores are dropped and memory is unchanged.
- **Load:** synchronous read. On a rising edge with `LeerMem=1` and `mis=0`, `DatoLeidoWB <= mem[idx]`.
  - If `LeerMem=0`, `DatoLeidoWB <= 0`.
  - If the load is misaligned, `DatoLeidoWB <= 0`.
- **Simultaneous `LeerMem` and `EscrMem` at the same aligned index:** read-before-write. `DatoLeidoWB` gets the old contents and memory gets `DatoEscr`.
- **MEM/WB register, every rising edge not in reset:**
  - `EscrRegWB <= Controls2[5] & ~mis`
  - `MemaRegWB <= Controls2[6]`
  - `ResultadoWB <= ResultadoALU`
  - `RegDestinoWB <= RegDestino`
  - `ErrorAlin <= mis`
- **Memory array:** not reset. Its contents are undefined until written, and the bench must write before reading.
- **No stall or flush inputs:** the stage advances every cycle. Instructions already in MEM are older than any branch and are never squashed.

## Timing
- **Reset:** while `reset=1`, asynchronously and immediately:
  - `EscrRegWB`, `MemaRegWB` and `ErrorAlin` are 0.
  - `DatoLeidoWB`, `ResultadoWB` and `RegDestinoWB` are all-zero.
  - `FuentePC` is 0.
  - Stores are inhibited.
- **Reset mid-operation:**
  - A store whose edge coincides with `reset=1` is not performed.
  - The first edge after reset deasserts behaves normally.
- **Latency:**
  - `FuentePC` and `DirSaltoPC` have 0 cycles of latency, valid in the same cycle as `control2`'s outputs.
  - All WB outputs have exactly 1 cycle of latency: the values present before edge N appear after edge N.
- **Store visibility:** a store at edge N is visible to a load sampled at edge N+1 or later.
- **`ErrorAlin`:** high for exactly the one cycle following the offending edge. Back-to-back misaligned accesses keep it high continuously.

## Test plan
1. **Reset:** assert `reset` mid-cycle with nonzero inputs → all WB outputs, `ErrorAlin` and `FuentePC` go to 0 without waiting for a clock edge.
2. **Store then load:**
   - Store 0xDEADBEEF at address 0x10, then load 0x10 on the next cycle → `DatoLeidoWB`=0xDEADBEEF, `MemaRegWB`=1, `RegDestinoWB` matches the load's rt.
   - Load 0x90 with `PROF_MEM`=32 → also returns 0xDEADBEEF (wrap-around).
3. **Read-before-write:** with mem[4]=0x11111111, apply `LeerMem=1`, `EscrMem=1`, address 0x10, data 0x22222222 → `DatoLeidoWB`=0x11111111; a following load returns 0x22222222.
4. **Misaligned store:** store at address 0x13 → next cycle `ErrorAlin`=1 and `EscrRegWB`=0; memory word 4 is unchanged; `ErrorAlin` returns to 0 one cycle later.
5. **Branch:**
   - `SaltoCond=1`, `Zero=1`, `DirSalto`=0x40 → `FuentePC`=1 and `DirSaltoPC`=0x40 in the same cycle.
   - `SaltoCond=1`, `Zero=0` → `FuentePC`=0.
   - `SaltoCond=0`, `Zero=1` → `FuentePC`=0.
6. **R-type pass-through:** `Controls2`=10'b0100100010 (EscrReg=1, MemaReg=0), `ResultadoALU`=0x7, `RegDestino`=9 → after one edge `EscrRegWB`=1, `MemaRegWB`=0, `ResultadoWB`=0x7, `RegDestinoWB`=9, `DatoLeidoWB`=0.

Source files
------------

// File: rtl/etapa_mem.sv
// etapa_mem: memory stage of the segmented processor.
// Performs the data-memory access, resolves the conditional branch and
// registers the write-back bundle into the MEM/WB pipeline register.
module etapa_mem #(
  parameter int ANCHO    = 32,
  parameter int PROF_MEM = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       Controls2,
  input  logic             LeerMem,
  input  logic             EscrMem,
  input  logic             SaltoCond,
  input  logic             Zero,
  input  logic [ANCHO-1:0] ResultadoALU,
  input  logic [ANCHO-1:0] DatoEscr,
  input  logic [4:0]       RegDestino,
  input  logic [ANCHO-1:0] DirSalto,
  output logic             FuentePC,
  output logic [ANCHO-1:0] DirSaltoPC,
  output logic             EscrRegWB,
  output logic             MemaRegWB,
  output logic [ANCHO-1:0] DatoLeidoWB,
  output logic [ANCHO-1:0] ResultadoWB,
  output logic [4:0]       RegDestinoWB,
  output logic             ErrorAlin
);

  localparam int AW = $clog2(PROF_MEM);

  logic [ANCHO-1:0] mem [PROF_MEM];

  logic [AW-1:0]    idx;
  logic             mis;

  logic             escr_reg_d,    escr_reg_q;
  logic             mema_reg_d,    mema_reg_q;
  logic [ANCHO-1:0] dato_leido_d,  dato_leido_q;
  logic [ANCHO-1:0] resultado_d,   resultado_q;
  logic [4:0]       reg_destino_d, reg_destino_q;
  logic             error_alin_d,  error_alin_q;

  // Control bits and upper address bits that this stage does not consume.
  logic unused_bits;
  assign unused_bits = ^{Controls2[9:7], Controls2[4:0], ResultadoALU[ANCHO-1:AW+2]};

  // Word index, alignment check and branch resolution (combinational).
  always_comb begin
    idx        = ResultadoALU[AW+1:2];
    mis        = (LeerMem | EscrMem) & (ResultadoALU[1:0] != 2'b00);
    FuentePC   = SaltoCond & Zero & ~reset;
    DirSaltoPC = DirSalto;
  end

  // Next-state values of the MEM/WB register; the read sees the pre-edge
  // contents, which gives read-before-write on a same-index load/store.
  always_comb begin
    escr_reg_d    = Controls2[5] & ~mis;
    mema_reg_d    = Controls2[6];
    dato_leido_d  = '0;
    if (LeerMem && !mis) begin
      dato_leido_d = mem[idx];
    end
    resultado_d   = ResultadoALU;
    reg_destino_d = RegDestino;
    error_alin_d  = mis;
  end

  // Data memory write port; array is not reset, stores are inhibited in reset.
  always_ff @(posedge clk) begin
    if (!reset && EscrMem && !mis) begin
      mem[idx] <= DatoEscr;
    end
  end

  // MEM/WB pipeline register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      escr_reg_q    <= 1'b0;
      mema_reg_q    <= 1'b0;
      dato_leido_q  <= '0;
      resultado_q   <= '0;
      reg_destino_q <= '0;
      error_alin_q  <= 1'b0;
    end else begin
      escr_reg_q    <= escr_reg_d;
      mema_reg_q    <= mema_reg_d;
      dato_leido_q  <= dato_leido_d;
      resultado_q   <= resultado_d;
      reg_destino_q <= reg_destino_d;
      error_alin_q  <= error_alin_d;
    end
  end

  assign EscrRegWB    = escr_reg_q;
  assign MemaRegWB    = mema_reg_q;
  assign DatoLeidoWB  = dato_leido_q;
  assign ResultadoWB  = resultado_q;
  assign RegDestinoWB = reg_destino_q;
  assign ErrorAlin    = error_alin_q;

endmodule

// File: tb/tb_etapa_mem.sv
// Directed self-checking bench for etapa_mem.
module tb_etapa_mem;

  logic        clk;
  logic        reset;
  logic [9:0]  Controls2;
  logic        LeerMem;
  logic        EscrMem;
  logic        SaltoCond;
  logic        Zero;
  logic [31:0] ResultadoALU;
  logic [31:0] DatoEscr;
  logic [4:0]  RegDestino;
  logic [31:0] DirSalto;
  logic        FuentePC;
  logic [31:0] DirSaltoPC;
  logic        EscrRegWB;
  logic        MemaRegWB;
  logic [31:0] DatoLeidoWB;
  logic [31:0] ResultadoWB;
  logic [4:0]  RegDestinoWB;
  logic        ErrorAlin;

  int errors = 0;
  int checks = 0;

  localparam logic [9:0] CTL_LOAD  = 10'b0001100000; // MemaReg=1, EscrReg=1
  localparam logic [9:0] CTL_RTYPE = 10'b0100100010; // EscrReg=1, MemaReg=0

  etapa_mem #(.ANCHO(32), .PROF_MEM(32)) dut (
    .clk(clk), .reset(reset), .Controls2(Controls2), .LeerMem(LeerMem),
    .EscrMem(EscrMem), .SaltoCond(SaltoCond), .Zero(Zero),
    .ResultadoALU(ResultadoALU), .DatoEscr(DatoEscr), .RegDestino(RegDestino),
    .DirSalto(DirSalto), .FuentePC(FuentePC), .DirSaltoPC(DirSaltoPC),
    .EscrRegWB(EscrRegWB), .MemaRegWB(MemaRegWB), .DatoLeidoWB(DatoLeidoWB),
    .ResultadoWB(ResultadoWB), .RegDestinoWB(RegDestinoWB), .ErrorAlin(ErrorAlin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    Controls2 = '0; LeerMem = 0; EscrMem = 0; SaltoCond = 0; Zero = 0;
    ResultadoALU = '0; DatoEscr = '0; RegDestino = '0; DirSalto = '0;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    idle();
    EscrMem = 1; ResultadoALU = addr; DatoEscr = data;
    step();
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [4:0] rt);
    idle();
    LeerMem = 1; Controls2 = CTL_LOAD; ResultadoALU = addr; RegDestino = rt;
    step();
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    step();
    step();
    checks++;
    if ({EscrRegWB, MemaRegWB, ErrorAlin, FuentePC} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {EscrRegWB, MemaRegWB, ErrorAlin, FuentePC});
    end
    checks++;
    if ({DatoLeidoWB, ResultadoWB, RegDestinoWB} !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%h/%0d exp=0", DatoLeidoWB, ResultadoWB, RegDestinoWB);
    end
    reset = 0;
  endtask

  task automatic test_store_load();
    do_store(32'h10, 32'hDEADBEEF);
    do_load(32'h10, 5'd8);
    checks++;
    if (DatoLeidoWB !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_data got=%h exp=deadbeef", DatoLeidoWB);
    end
    checks++;
    if ({MemaRegWB, EscrRegWB, ErrorAlin} !== 3'b110) begin
      errors++; $display("FAIL load_ctl got=%b exp=110", {MemaRegWB, EscrRegWB, ErrorAlin});
    end
    checks++;
    if (RegDestinoWB !== 5'd8) begin
      errors++; $display("FAIL load_rd got=%0d exp=8", RegDestinoWB);
    end
    do_load(32'h90, 5'd3);
    checks++;
    if (DatoLeidoWB !== 32'hDEADBEEF || ResultadoWB !== 32'h90) begin
      errors++; $display("FAIL load_wrap got=%h res=%h exp=deadbeef res=90", DatoLeidoWB, ResultadoWB);
    end
  endtask

  task automatic test_read_before_write();
    do_store(32'h10, 32'h11111111);
    idle();
    LeerMem = 1; EscrMem = 1; Controls2 = CTL_LOAD;
    ResultadoALU = 32'h10; DatoEscr = 32'h22222222; RegDestino = 5'd4;
    step();
    checks++;
    if (DatoLeidoWB !== 32'h11111111) begin
      errors++; $display("FAIL rbw_old got=%h exp=11111111", DatoLeidoWB);
    end
    do_load(32'h10, 5'd5);
    checks++;
    if (DatoLeidoWB !== 32'h22222222) begin
      errors++; $display("FAIL rbw_new got=%h exp=22222222", DatoLeidoWB);
    end
  endtask

  task automatic test_misaligned();
    idle();
    EscrMem = 1; Controls2 = CTL_RTYPE; ResultadoALU = 32'h13; DatoEscr = 32'hBAD0BAD0;
    step();
    checks++;
    if ({ErrorAlin, EscrRegWB} !== 2'b10 || DatoLeidoWB !== 32'h0) begin
      errors++; $display("FAIL mis_store got=err%b wr%b d=%h exp=err1 wr0 d=0", ErrorAlin, EscrRegWB, DatoLeidoWB);
    end
    do_load(32'h10, 5'd6);
    checks++;
    if (ErrorAlin !== 1'b0) begin
      errors++; $display("FAIL mis_clear got=%b exp=0", ErrorAlin);
    end
    checks++;
    if (DatoLeidoWB !== 32'h22222222) begin
      errors++; $display("FAIL mis_mem_kept got=%h exp=22222222", DatoLeidoWB);
    end
    do_load(32'h11, 5'd7);
    checks++;
    if ({ErrorAlin, EscrRegWB} !== 2'b10 || DatoLeidoWB !== 32'h0) begin
      errors++; $display("FAIL mis_load got=err%b wr%b d=%h exp=err1 wr0 d=0", ErrorAlin, EscrRegWB, DatoLeidoWB);
    end
    do_load(32'h12, 5'd7);
    checks++;
    if (ErrorAlin !== 1'b1) begin
      errors++; $display("FAIL mis_b2b got=%b exp=1", ErrorAlin);
    end
  endtask

  task automatic test_branch();
    idle();
    SaltoCond = 1; Zero = 1; DirSalto = 32'h40;
    #1;
    checks++;
    if (FuentePC !== 1'b1 || DirSaltoPC !== 32'h40) begin
      errors++; $display("FAIL br_taken got=%b %h exp=1 40", FuentePC, DirSaltoPC);
    end
    Zero = 0;
    #1;
    checks++;
    if (FuentePC !== 1'b0) begin
      errors++; $display("FAIL br_nz got=%b exp=0", FuentePC);
    end
    SaltoCond = 0; Zero = 1;
    #1;
    checks++;
    if (FuentePC !== 1'b0) begin
      errors++; $display("FAIL br_nocond got=%b exp=0", FuentePC);
    end
  endtask

  task automatic test_rtype();
    idle();
    Controls2 = CTL_RTYPE; ResultadoALU = 32'h7; RegDestino = 5'd9;
    step();
    checks++;
    if ({EscrRegWB, MemaRegWB, ErrorAlin} !== 3'b100) begin
      errors++; $display("FAIL rtype_ctl got=%b exp=100", {EscrRegWB, MemaRegWB, ErrorAlin});
    end
    checks++;
    if (ResultadoWB !== 32'h7 || RegDestinoWB !== 5'd9 || DatoLeidoWB !== 32'h0) begin
      errors++; $display("FAIL rtype_data got=%h %0d %h exp=7 9 0", ResultadoWB, RegDestinoWB, DatoLeidoWB);
    end
  endtask

  task automatic test_reset_mid();
    do_store(32'h20, 32'hA5A5A5A5);
    do_load(32'h20, 5'd12);
    checks++;
    if (DatoLeidoWB !== 32'hA5A5A5A5 || RegDestinoWB !== 5'd12) begin
      errors++; $display("FAIL pre_reset got=%h %0d exp=a5a5a5a5 12", DatoLeidoWB, RegDestinoWB);
    end
    // Nonzero inputs, including a pending store and a taken branch.
    idle();
    EscrMem = 1; ResultadoALU = 32'h20; DatoEscr = 32'h5A5A5A5A;
    Controls2 = CTL_LOAD; RegDestino = 5'd13; SaltoCond = 1; Zero = 1;
    #2;
    reset = 1;
    #1;
    checks++;
    if ({EscrRegWB, MemaRegWB, ErrorAlin, FuentePC} !== 4'b0 ||
        {DatoLeidoWB, ResultadoWB, RegDestinoWB} !== '0) begin
      errors++; $display("FAIL reset_async got=%b %h %h %0d exp=0",
        {EscrRegWB, MemaRegWB, ErrorAlin, FuentePC}, DatoLeidoWB, ResultadoWB, RegDestinoWB);
    end
    step();
    checks++;
    if ({DatoLeidoWB, ResultadoWB, RegDestinoWB} !== '0 || EscrRegWB !== 1'b0) begin
      errors++; $display("FAIL reset_hold got=%h %h %0d exp=0", DatoLeidoWB, ResultadoWB, RegDestinoWB);
    end
    reset = 0;
    do_load(32'h20, 5'd14);
    checks++;
    if (DatoLeidoWB !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL reset_store_inhib got=%h exp=a5a5a5a5", DatoLeidoWB);
    end
    checks++;
    if (RegDestinoWB !== 5'd14 || MemaRegWB !== 1'b1) begin
      errors++; $display("FAIL post_reset got=%0d %b exp=14 1", RegDestinoWB, MemaRegWB);
    end
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_store_load();
    test_read_before_write();
    test_misaligned();
    test_branch();
    test_rtype();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
